// File: rtl/evt_decoder.sv
// evt_decoder: buffers encoded pixel-event words in a small FIFO, screens out
// illegal words, presents legal ones on a valid/ready port and reports per-group
// ON/OFF tallies with a one-cycle grp_done_o pulse.
module evt_decoder #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int POLARITY  = 2,
  parameter int DEPTH     = 4,
  localparam int ROW_W    = $clog2(ROWS),
  localparam int COL_W    = $clog2(COLS),
  localparam int WIDTH    = ROW_W + COL_W + POLARITY,
  localparam int CNT_W    = $clog2(ROWS*COLS+1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             evt_valid_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             grp_release_i,
  output logic             evt_ready_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             pol_o,
  output logic             grp_done_o,
  output logic [CNT_W-1:0] on_cnt_o,
  output logic [CNT_W-1:0] off_cnt_o,
  output logic             err_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH+1);
  localparam int ENT_W  = WIDTH + 1;

  localparam logic [FCNT_W-1:0]   FIFO_FULL = FCNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0]   FIFO_NONE = FCNT_W'(0);
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(ROWS*COLS);
  localparam logic [ROW_W:0]      ROW_LIM   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]      COL_LIM   = (COL_W+1)'(COLS);
  localparam logic [POLARITY-1:0] POL_ON    = POLARITY'(1);
  localparam logic [POLARITY-1:0] POL_OFF   = POLARITY'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GRP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FCNT_W-1:0] r_count;
  logic              r_ready;

  // Decode FSM state and registered outputs
  state_t            r_state;
  logic              r_tag;
  logic              r_pix_valid;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic              r_pol;
  logic              r_grp_done;
  logic [CNT_W-1:0]  r_on_cnt;
  logic [CNT_W-1:0]  r_off_cnt;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic [FCNT_W-1:0] w_count_nxt;
  logic [ENT_W-1:0]  w_head;
  logic              w_tag;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [POLARITY-1:0] w_pol;
  logic              w_legal;

  // The FSM only pops while IDLE, so the pop never depends on pix_ready_i.
  assign w_push = evt_valid_i & r_ready;
  assign w_pop  = (r_state == ST_IDLE) && (r_count != FIFO_NONE);

  // Head-of-FIFO field split: entry is {row, col, pol, tag}.
  assign w_head = r_mem[r_rptr];
  assign w_tag  = w_head[0];
  assign w_pol  = w_head[POLARITY:1];
  assign w_col  = w_head[POLARITY+1 +: COL_W];
  assign w_row  = w_head[ENT_W-1 -: ROW_W];

  // Next occupancy and legality of the head entry.
  always_comb begin
    w_count_nxt = r_count;
    w_legal     = 1'b0;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + FCNT_W'(1);
      2'b01:   w_count_nxt = r_count - FCNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
    if (((w_pol == POL_ON) || (w_pol == POL_OFF)) &&
        ({1'b0, w_row} < ROW_LIM) && ({1'b0, w_col} < COL_LIM)) begin
      w_legal = 1'b1;
    end else begin
      w_legal = 1'b0;
    end
  end

  // FIFO data array write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {data_in_i, grp_release_i};
    end
  end

  // FIFO pointers, occupancy and registered ready (low during reset).
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FIFO_FULL);
    end
  end

  // Decode FSM: pop/screen in IDLE, hand over in XFER, report tallies in GRP.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= ST_IDLE;
      r_tag       <= 1'b0;
      r_pix_valid <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_pol       <= 1'b0;
      r_grp_done  <= 1'b0;
      r_on_cnt    <= '0;
      r_off_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_grp_done <= 1'b0;
          if (w_pop) begin
            if (w_legal) begin
              r_row       <= w_row;
              r_col       <= w_col;
              r_pol       <= (w_pol == POL_ON);
              r_tag       <= w_tag;
              r_pix_valid <= 1'b1;
              r_state     <= ST_XFER;
            end else begin
              // Illegal word is dropped, but a group tag on it still closes the group.
              r_err <= 1'b1;
              if (w_tag) begin
                r_grp_done <= 1'b1;
                r_state    <= ST_GRP;
              end
            end
          end
        end
        ST_XFER: begin
          if (pix_ready_i) begin
            r_pix_valid <= 1'b0;
            if (r_pol) begin
              if (r_on_cnt != CNT_MAX) r_on_cnt <= r_on_cnt + CNT_W'(1);
            end else begin
              if (r_off_cnt != CNT_MAX) r_off_cnt <= r_off_cnt + CNT_W'(1);
            end
            if (r_tag) begin
              r_grp_done <= 1'b1;
              r_state    <= ST_GRP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GRP: begin
          r_grp_done <= 1'b0;
          r_on_cnt   <= '0;
          r_off_cnt  <= '0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_pix_valid <= 1'b0;
          r_grp_done  <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign evt_ready_o = r_ready;
  assign pix_valid_o = r_pix_valid;
  assign row_o       = r_row;
  assign col_o       = r_col;
  assign pol_o       = r_pol;
  assign grp_done_o  = r_grp_done;
  assign on_cnt_o    = r_on_cnt;
  assign off_cnt_o   = r_off_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_evt_decoder.sv
// tb_evt_decoder: randomized stimulus with a queue-based reference model and a
// decoupled monitor that checks every decoded event and every group report.
module tb_evt_decoder;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int POLARITY = 2;
  localparam int DEPTH    = 4;
  localparam int ROW_W    = 2;
  localparam int COL_W    = 2;
  localparam int WIDTH    = 6;
  localparam int CNT_W    = 5;
  localparam int NPIX     = ROWS * COLS;

  typedef struct { int row; int col; int pol; } pix_t;
  typedef struct { int on; int off; } grp_t;

  logic             clk_i = 1'b0;
  logic             reset_ni = 1'b0;
  logic             evt_valid_i = 1'b0;
  logic [WIDTH-1:0] data_in_i = '0;
  logic             grp_release_i = 1'b0;
  logic             evt_ready_o;
  logic             pix_valid_o;
  logic             pix_ready_i = 1'b0;
  logic [ROW_W-1:0] row_o;
  logic [COL_W-1:0] col_o;
  logic             pol_o;
  logic             grp_done_o;
  logic [CNT_W-1:0] on_cnt_o;
  logic [CNT_W-1:0] off_cnt_o;
  logic             err_o;

  evt_decoder #(.ROWS(ROWS), .COLS(COLS), .POLARITY(POLARITY), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .evt_valid_i(evt_valid_i),
    .data_in_i(data_in_i), .grp_release_i(grp_release_i), .evt_ready_o(evt_ready_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .row_o(row_o),
    .col_o(col_o), .pol_o(pol_o), .grp_done_o(grp_done_o), .on_cnt_o(on_cnt_o),
    .off_cnt_o(off_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  pix_t pix_q[$];
  grp_t grp_q[$];
  int   m_on  = 0;
  int   m_off = 0;
  int   m_err = 0;
  int   rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one accepted beat, described by the event-word rules.
  task automatic model_accept(int word, bit tag);
    int row;
    int col;
    int pol;
    row = word / (1 << (COL_W + POLARITY));
    col = (word / (1 << POLARITY)) % (1 << COL_W);
    pol = word % (1 << POLARITY);
    if ((pol == 1 || pol == 2) && row < ROWS && col < COLS) begin
      pix_q.push_back('{row, col, (pol == 1) ? 1 : 0});
      if (pol == 1) m_on  = (m_on  + 1 > NPIX) ? NPIX : m_on  + 1;
      else          m_off = (m_off + 1 > NPIX) ? NPIX : m_off + 1;
    end else begin
      m_err = 1;
    end
    if (tag) begin
      grp_q.push_back('{m_on, m_off});
      m_on  = 0;
      m_off = 0;
    end
  endtask

  function automatic int legal_word(int pol);
    return int'($urandom_range(0, ROWS-1)) * 16 + int'($urandom_range(0, COLS-1)) * 4 + pol;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(int word, bit tag);
    int waited;
    bit acc;
    waited = 0;
    evt_valid_i   = 1'b1;
    data_in_i     = WIDTH'(word);
    grp_release_i = tag;
    forever begin
      acc = evt_ready_o;
      @(posedge clk_i); #1;
      if (acc) begin
        model_accept(word, tag);
        break;
      end
      waited++;
      if (waited > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat %0d not accepted within %0d cycles", word, waited);
        break;
      end
    end
    evt_valid_i   = 1'b0;
    grp_release_i = 1'b0;
  endtask

  task automatic drain(int budget);
    int c;
    c = 0;
    while ((pix_q.size() != 0 || grp_q.size() != 0) && c < budget) begin
      @(posedge clk_i); #1;
      c++;
    end
    n_checks++;
    if (pix_q.size() != 0 || grp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events and %0d groups still pending after %0d cycles",
               pix_q.size(), grp_q.size(), c);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        0:       pix_ready_i = 1'b0;
        1:       pix_ready_i = 1'b1;
        default: pix_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event or a group report.
  initial begin
    bit   hold;
    bit   post_grp;
    pix_t held;
    pix_t e;
    grp_t g;
    hold = 1'b0;
    post_grp = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        hold = 1'b0;
        post_grp = 1'b0;
      end else begin
        if (post_grp) begin
          check("cnt_clear_on", int'(on_cnt_o), 0);
          check("cnt_clear_off", int'(off_cnt_o), 0);
          check("grp_done_one_cycle", int'(grp_done_o), 0);
          post_grp = 1'b0;
        end
        if (hold) begin
          check("hold_valid", int'(pix_valid_o), 1);
          check("hold_row", int'(row_o), held.row);
          check("hold_col", int'(col_o), held.col);
          check("hold_pol", int'(pol_o), held.pol);
        end
        hold = 1'b0;
        if (pix_valid_o) begin
          check("valid_with_grp_done", int'(grp_done_o), 0);
          if (pix_ready_i) begin
            n_checks++;
            if (pix_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_pix: row %0d col %0d pol %0d with nothing expected",
                       row_o, col_o, pol_o);
            end else begin
              e = pix_q.pop_front();
              check("pix_row", int'(row_o), e.row);
              check("pix_col", int'(col_o), e.col);
              check("pix_pol", int'(pol_o), e.pol);
            end
          end else begin
            hold = 1'b1;
            held = '{int'(row_o), int'(col_o), int'(pol_o)};
          end
        end
        if (grp_done_o) begin
          n_checks++;
          if (grp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_grp: on %0d off %0d with no group expected",
                     on_cnt_o, off_cnt_o);
          end else begin
            g = grp_q.pop_front();
            check("grp_on", int'(on_cnt_o), g.on);
            check("grp_off", int'(off_cnt_o), g.off);
          end
          post_grp = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pols[16];
    int tmp;
    int j;
    int act;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_pix_valid", int'(pix_valid_o), 0);
    check("rst_evt_ready", int'(evt_ready_o), 0);
    check("rst_grp_done", int'(grp_done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_on_cnt", int'(on_cnt_o), 0);
    check("rst_off_cnt", int'(off_cnt_o), 0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_reset", int'(evt_ready_o), 1);

    // Single tagged event and its two-cycle latency
    rdy_mode = 1;
    @(posedge clk_i); #1;
    send(6'b10_01_01, 1'b1);
    @(negedge clk_i);
    check("latency_cycle1_valid", int'(pix_valid_o), 0);
    @(negedge clk_i);
    check("latency_cycle2_valid", int'(pix_valid_o), 1);
    @(posedge clk_i); #1;
    drain(20);
    check("err_clean", int'(err_o), m_err);

    // Backpressure: four buffered plus one in XFER fills the block
    rdy_mode = 0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) send(legal_word(int'($urandom_range(1, 2))), 1'b0);
    check("bp_ready_low", int'(evt_ready_o), 0);
    evt_valid_i = 1'b1;
    data_in_i   = WIDTH'(legal_word(1));
    repeat (4) @(posedge clk_i);
    #1;
    check("bp_ready_still_low", int'(evt_ready_o), 0);
    check("bp_valid_held", int'(pix_valid_o), 1);
    rdy_mode = 1;
    send(legal_word(2), 1'b1);
    drain(100);

    // Illegal words, then a tagged OFF event
    rdy_mode = 2;
    send(legal_word(3) & 32'h3F, 1'b0);
    send(legal_word(0) & 32'h3F, 1'b0);
    send(legal_word(2), 1'b1);
    drain(100);
    check("err_set", int'(err_o), m_err);

    // Full group of 8 ON and 8 OFF, shuffled, random downstream ready
    for (int i = 0; i < 16; i++) pols[i] = (i < 8) ? 1 : 2;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = pols[i];
      pols[i] = pols[j];
      pols[j] = tmp;
    end
    for (int i = 0; i < 16; i++) send(legal_word(pols[i]), (i == 15));
    drain(400);

    // Counter saturation: 19 ON events in one group
    rdy_mode = 1;
    for (int i = 0; i < 19; i++) send(legal_word(1), (i == 18));
    drain(200);

    // Reset with three entries buffered and one event presented
    rdy_mode = 0;
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) send(legal_word(1), (i == 3));
    check("pre_reset_valid", int'(pix_valid_o), 1);
    #2;
    reset_ni = 1'b0;
    #1;
    check("mid_rst_pix_valid", int'(pix_valid_o), 0);
    check("mid_rst_evt_ready", int'(evt_ready_o), 0);
    check("mid_rst_err", int'(err_o), 0);
    check("mid_rst_on_cnt", int'(on_cnt_o), 0);
    pix_q.delete();
    grp_q.delete();
    m_on = 0;
    m_off = 0;
    m_err = 0;
    rdy_mode = 1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    act = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (pix_valid_o || grp_done_o) act++;
    end
    check("post_reset_quiet", act, 0);
    check("post_reset_ready", int'(evt_ready_o), 1);
    @(posedge clk_i); #1;

    // Streaming: 100 random events back to back with downstream always ready
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 7) == 0) tmp = int'($urandom_range(0, 63));
      else                           tmp = legal_word(int'($urandom_range(1, 2)));
      send(tmp, (i == 99) || ($urandom_range(0, 9) == 0));
    end
    drain(1000);
    check("stream_err", int'(err_o), m_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
